stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the four stopwatch buttons, runs the run/pause/lap
// state machine and derives the count tick plus clear/lap/hold controls.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 10000000,
    parameter int DEB_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic       at_max,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LAP   = 2;
    localparam int B_CLR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    logic [3:0]         btn_raw;
    logic [3:0]         sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, evt_q, evt_d;
    logic [3:0][DW-1:0] cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [PW-1:0]      psc_q, psc_d;
    logic               tick_q, tick_d, clr_q, clr_d, lap_q, lap_d;
    logic               hold_q, hold_d, ovf_q, ovf_d;
    logic               running, wrap, ovf_hit;

    assign btn_raw = {btn_clr, btn_lap, btn_stop, btn_start};
    assign running = (state_q == RUN) || (state_q == LAP);
    assign wrap    = psc_q == PSC_MAX;
    assign ovf_hit = running && wrap && at_max;

    // Debounce: the accepted level flips once the synchronised input has
    // disagreed with it for DEB_CYCLES consecutive samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != DEB_MAX) ? cnt_q[i] + 1'b1 : '0;
            deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == DEB_MAX) ? ~deb_q[i] : deb_q[i];
        end
        evt_d = deb_q & ~deb_dly_q;
    end

    // Only the highest-priority event legal in the current state is taken.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        clr_d   = 1'b0;
        if (evt_q[B_CLR]) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
            clr_d   = 1'b1;
        end else if (ovf_hit) begin
            state_d = PAUSE;
            ovf_d   = 1'b1;
        end else if (evt_q[B_STOP] && running) begin
            state_d = PAUSE;
        end else if (evt_q[B_START] && (state_q == IDLE || (state_q == PAUSE && !ovf_q))) begin
            state_d = RUN;
        end else if (evt_q[B_LAP] && running) begin
            state_d = (state_q == RUN) ? LAP : RUN;
        end
        psc_d  = (evt_q[B_CLR] || state_q == IDLE) ? '0 : !running ? psc_q : wrap ? '0 : psc_q + 1'b1;
        tick_d = running && wrap && !at_max && !evt_q[B_CLR];
        lap_d  = state_d == LAP && state_q != LAP;
        hold_d = state_d == LAP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            evt_q     <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            psc_q     <= '0;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
            lap_q     <= 1'b0;
            hold_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            evt_q     <= evt_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            psc_q     <= psc_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
            lap_q     <= lap_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tick_en   = tick_q;
    assign cnt_clr   = clr_q;
    assign lap_load  = lap_q;
    assign disp_hold = hold_q;
    assign state     = state_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed button sequences; expected output events are queued
// with their cycle numbers and a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0, at_max = 1'b0;
    logic       tick_en, cnt_clr, lap_load, disp_hold, ovf;
    logic [1:0] state;

    stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_lap(btn_lap), .btn_clr(btn_clr), .at_max(at_max), .tick_en(tick_en),
        .cnt_clr(cnt_clr), .lap_load(lap_load), .disp_hold(disp_hold),
        .state(state), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
        string      n;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_chk = 0, n_pass = 0;
    logic [6:0] vec;
    logic [1:0] prev_state = 2'b00;

    assign vec = {state, tick_en, cnt_clr, lap_load, disp_hold, ovf};

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_LAP = 2'b11;

    task automatic check(string name, int got, int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [6:0] v(logic [1:0] s, logic t, logic c, logic l, logic d, logic o);
        return {s, t, c, l, d, o};
    endfunction

    task automatic push(int c, logic [6:0] ev, string n);
        q.push_back('{c, ev, n});
    endtask

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Event = state change or any pulse output high.
    always @(negedge clk) begin
        if (rst_n && (state != prev_state || tick_en || cnt_clr || lap_load)) begin
            if (q.size() == 0) begin
                check("spurious_event", cyc, -1);
            end else begin
                e = q.pop_front();
                check({e.n, "_cycle"}, cyc, e.c);
                check({e.n, "_outputs"}, int'(vec), int'(e.v));
            end
        end
        prev_state = state;
    end

    localparam int K = 5;
    localparam int B = K + 130;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(vec), 0);
        rst_n = 1'b1;

        wait_until(K);
        btn_start = 1'b1;
        push(K + 7, v(S_RUN, 0, 0, 0, 0, 0), "start_run");
        push(K + 11, v(S_RUN, 1, 0, 0, 0, 0), "tick_first");
        push(K + 15, v(S_RUN, 1, 0, 0, 0, 0), "tick_second");
        wait_until(K + 10);
        btn_start = 1'b0;

        wait_until(K + 11);
        btn_stop = 1'b1;
        push(K + 18, v(S_PAUSE, 0, 0, 0, 0, 0), "stop_pause");
        wait_until(K + 21);
        btn_stop = 1'b0;

        wait_until(K + 38);
        btn_start = 1'b1;
        push(K + 45, v(S_RUN, 0, 0, 0, 0, 0), "resume_run");
        push(K + 46, v(S_RUN, 1, 0, 0, 0, 0), "resume_tick");
        push(K + 50, v(S_RUN, 1, 0, 0, 0, 0), "run_tick");

        wait_until(K + 47);
        btn_lap = 1'b1;
        push(K + 54, v(S_LAP, 1, 0, 1, 1, 0), "lap_enter");
        for (int i = 58; i <= 70; i += 4) push(K + i, v(S_LAP, 1, 0, 0, 1, 0), "lap_tick");
        wait_until(K + 48);
        btn_start = 1'b0;
        wait_until(K + 57);
        btn_lap = 1'b0;

        wait_until(K + 64);
        btn_lap = 1'b1;
        push(K + 71, v(S_RUN, 0, 0, 0, 0, 0), "lap_exit");
        for (int i = 74; i <= 82; i += 4) push(K + i, v(S_RUN, 1, 0, 0, 0, 0), "post_lap_tick");
        wait_until(K + 74);
        btn_lap = 1'b0;

        wait_until(K + 76);
        btn_stop = 1'b1;
        btn_clr  = 1'b1;
        push(K + 83, v(S_IDLE, 0, 1, 0, 0, 0), "stop_clr_same");
        wait_until(K + 86);
        btn_stop = 1'b0;
        btn_clr  = 1'b0;

        wait_until(K + 90);
        btn_start = 1'b1;
        push(K + 97, v(S_RUN, 0, 0, 0, 0, 0), "ovf_run");
        push(K + 101, v(S_PAUSE, 0, 0, 0, 0, 1), "ovf_pause");
        wait_until(K + 100);
        btn_start = 1'b0;
        at_max    = 1'b1;
        wait_until(K + 106);
        btn_start = 1'b1;
        wait_until(K + 111);
        btn_start = 1'b0;
        wait_until(K + 115);
        btn_clr = 1'b1;
        push(K + 122, v(S_IDLE, 0, 1, 0, 0, 0), "ovf_clear");
        wait_until(K + 125);
        btn_clr = 1'b0;
        at_max  = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_until(B + i);
            btn_start = (i % 2 == 0);
        end
        push(B + 11, v(S_RUN, 0, 0, 0, 0, 0), "bounce_run");
        push(B + 15, v(S_RUN, 1, 0, 0, 0, 0), "bounce_tick1");
        push(B + 19, v(S_RUN, 1, 0, 0, 0, 0), "bounce_tick2");
        wait_until(B + 13);
        btn_clr = 1'b1;
        push(B + 20, v(S_IDLE, 0, 1, 0, 0, 0), "run_clear");
        wait_until(B + 14);
        btn_start = 1'b0;
        wait_until(B + 20);
        btn_clr = 1'b0;

        wait_until(B + 30);
        btn_clr = 1'b1;
        push(B + 37, v(S_IDLE, 0, 1, 0, 0, 0), "clr_in_idle");
        wait_until(B + 40);
        btn_clr = 1'b0;

        wait_until(B + 50);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
